// File: rtl/bus_cmd_ctrl.sv
// rtl/bus_cmd_ctrl.sv - 8288-style bus command controller with wait states and watchdog
//
// Decodes 8088 status lines into system-bus command strobes and buffer
// controls. One bus cycle runs IDLE -> T1 -> T2 -> T3 -> {TW} -> T4 -> IDLE.
//
// Parameters:
//   NUM_WAIT  mandatory wait states inserted in every cycle
//   TIMEOUT   wait count at which the cycle is forced to end (0 = off)
//   CNT_W     wait counter width, must hold max(NUM_WAIT, TIMEOUT)
//
// Ports:
//   clk, reset_n              bus clock, asynchronous active-low reset
//   s_n[2:0]                  CPU status lines
//   aen_n                     address enable, gates command strobes
//   cen                       command enable, forces all outputs idle when low
//   ready                     synchronised READY, ends wait states
//   mrdc_n, mwtc_n, amwc_n    memory read / write / advanced write
//   iorc_n, iowc_n, aiowc_n   I/O read / write / advanced write
//   inta_n                    interrupt acknowledge
//   ale, dtr, den, mce        address latch, direction, buffer enable, cascade
//   bus_timeout               one-cycle pulse in T4 of a watchdog-ended cycle

module bus_cmd_ctrl #(
    parameter int NUM_WAIT = 0,
    parameter int TIMEOUT  = 0,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] s_n,
    input  logic       aen_n,
    input  logic       cen,
    input  logic       ready,
    output logic       mrdc_n,
    output logic       mwtc_n,
    output logic       amwc_n,
    output logic       iorc_n,
    output logic       iowc_n,
    output logic       aiowc_n,
    output logic       inta_n,
    output logic       ale,
    output logic       dtr,
    output logic       den,
    output logic       mce,
    output logic       bus_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_T1, ST_T2, ST_T3, ST_TW, ST_T4
    } state_t;

    typedef enum logic [2:0] {
        TY_NONE, TY_READ, TY_WRITE, TY_IORD, TY_IOWR, TY_INTA
    } cyc_t;

    localparam logic [CNT_W-1:0] LP_NUM_WAIT = CNT_W'(NUM_WAIT);
    localparam logic [CNT_W-1:0] LP_TIMEOUT  = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_next;
    cyc_t             r_type;
    cyc_t             w_type_next;
    cyc_t             w_s_type;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_next;
    logic             r_bto;
    logic             w_bto_next;
    logic             w_min_met;
    logic             w_to_hit;

    // Constant comparisons are resolved at elaboration so a zero parameter
    // leaves no always-true/always-false compare behind.
    generate
        if (NUM_WAIT == 0) begin : g_no_min_wait
            assign w_min_met = 1'b1;
        end else begin : g_min_wait
            assign w_min_met = (r_wcnt >= LP_NUM_WAIT);
        end
        if (TIMEOUT == 0) begin : g_no_watchdog
            assign w_to_hit = 1'b0;
        end else begin : g_watchdog
            assign w_to_hit = (r_wcnt == LP_TIMEOUT);
        end
    endgenerate

    // Status decode; halt and passive map to TY_NONE and never start a cycle.
    always_comb begin
        w_s_type = TY_NONE;
        case (s_n)
            3'b000:         w_s_type = TY_INTA;
            3'b001:         w_s_type = TY_IORD;
            3'b010:         w_s_type = TY_IOWR;
            3'b100, 3'b101: w_s_type = TY_READ;
            3'b110:         w_s_type = TY_WRITE;
            default:        w_s_type = TY_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_type  <= TY_NONE;
            r_wcnt  <= '0;
            r_bto   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_type  <= w_type_next;
            r_wcnt  <= w_wcnt_next;
            r_bto   <= w_bto_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_type_next  = r_type;
        w_wcnt_next  = r_wcnt;
        w_bto_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!aen_n && (w_s_type != TY_NONE)) begin
                    w_state_next = ST_T1;
                    w_type_next  = w_s_type;
                end
            end
            ST_T1: w_state_next = ST_T2;
            ST_T2: begin
                w_state_next = ST_T3;
                w_wcnt_next  = '0;
            end
            ST_T3, ST_TW: begin
                // Ready wins over the watchdog when both apply on the same edge.
                if (w_min_met && ready) begin
                    w_state_next = ST_T4;
                end else if (w_to_hit) begin
                    w_state_next = ST_T4;
                    w_bto_next   = 1'b1;
                end else begin
                    w_state_next = ST_TW;
                    if (!(&r_wcnt)) begin
                        w_wcnt_next = r_wcnt + CNT_W'(1);
                    end
                end
            end
            ST_T4:   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    logic w_t1_tw;
    logic w_t2_tw;
    logic w_t3_tw;
    logic w_rd_like;

    assign w_t1_tw   = (r_state == ST_T1) || (r_state == ST_T2) ||
                       (r_state == ST_T3) || (r_state == ST_TW);
    assign w_t2_tw   = (r_state == ST_T2) || (r_state == ST_T3) || (r_state == ST_TW);
    assign w_t3_tw   = (r_state == ST_T3) || (r_state == ST_TW);
    assign w_rd_like = (r_type == TY_READ) || (r_type == TY_IORD) || (r_type == TY_INTA);

    always_comb begin
        mrdc_n      = 1'b1;
        mwtc_n      = 1'b1;
        amwc_n      = 1'b1;
        iorc_n      = 1'b1;
        iowc_n      = 1'b1;
        aiowc_n     = 1'b1;
        inta_n      = 1'b1;
        ale         = 1'b0;
        dtr         = 1'b1;
        den         = 1'b0;
        mce         = 1'b0;
        bus_timeout = 1'b0;
        if (cen) begin
            ale         = (r_state == ST_T1);
            mce         = (r_state == ST_T1) && (r_type == TY_INTA);
            dtr         = !(w_t1_tw && w_rd_like);
            // Reads keep the buffer off in T1 so the bus can turn around.
            den         = w_rd_like ? w_t2_tw : w_t1_tw;
            bus_timeout = r_bto;
            // aen_n only blocks the strobes; ale/dtr/den keep following the FSM.
            if (!aen_n) begin
                mrdc_n  = !(w_t2_tw && (r_type == TY_READ));
                amwc_n  = !(w_t2_tw && (r_type == TY_WRITE));
                mwtc_n  = !(w_t3_tw && (r_type == TY_WRITE));
                iorc_n  = !(w_t2_tw && (r_type == TY_IORD));
                aiowc_n = !(w_t2_tw && (r_type == TY_IOWR));
                iowc_n  = !(w_t3_tw && (r_type == TY_IOWR));
                inta_n  = !(w_t2_tw && (r_type == TY_INTA));
            end
        end
    end

endmodule
